// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage load/store engine: access sizes, FSM
// states, data-bus request/response records and the alignment helper.
package mem_access_unit_pkg;

    localparam int unsigned MAU_ADDR_W = 64;
    localparam int unsigned MAU_DATA_W = 64;
    localparam int unsigned MAU_STRB_W = MAU_DATA_W / 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } mau_state_t;

    typedef struct packed {
        logic                  valid;
        logic [MAU_ADDR_W-1:0] addr;
        msize_t                size;
        logic [MAU_STRB_W-1:0] strobe;
        logic [MAU_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                  addr_ok;
        logic                  data_ok;
        logic [MAU_DATA_W-1:0] data;
    } dbus_resp_t;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic mau_misaligned(input logic [2:0] off, input msize_t size);
        logic r;
        case (size)
            MSIZE1:  r = 1'b0;
            MSIZE2:  r = off[0];
            MSIZE4:  r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus connection between the load/store engine (master) and memory (slave).
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment for the load/store engine: store strobes and lane-shifted
// store data, plus load extraction with sign/zero extension.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_off,
    input  msize_t      i_size,
    input  logic        i_unsigned,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_strobe,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata
);

    logic [5:0]  w_shamt;
    logic [63:0] w_raw;

    assign w_shamt = {i_off, 3'b000};
    assign w_raw   = i_rdata >> w_shamt;
    assign o_wdata = i_wdata << w_shamt;

    // Sub-dword strobes shifted past lane 7 are truncated to 8 bits.
    always_comb begin
        o_strobe = '0;
        case (i_size)
            MSIZE1:  o_strobe = 8'h01 << i_off;
            MSIZE2:  o_strobe = 8'h03 << i_off;
            MSIZE4:  o_strobe = 8'h0F << i_off;
            default: o_strobe = 8'hFF;
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_size)
            MSIZE1:  o_rdata = i_unsigned ? {56'd0, w_raw[7:0]}
                                          : {{56{w_raw[7]}}, w_raw[7:0]};
            MSIZE2:  o_rdata = i_unsigned ? {48'd0, w_raw[15:0]}
                                          : {{48{w_raw[15]}}, w_raw[15:0]};
            MSIZE4:  o_rdata = i_unsigned ? {32'd0, w_raw[31:0]}
                                          : {{32{w_raw[31]}}, w_raw[31:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one dbus transaction per request, pipeline
// stall until completion. Optional misaligned-access trap: MAU_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
`ifdef MAU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    mem_access_unit_if.master dbus
);

    mau_state_t        r_state;
    mau_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    msize_t            r_size;
    logic              r_write;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic              r_flush;
    logic [DATA_W-1:0] r_resp_data;
`ifdef MAU_MISALIGN_TRAP_EN
    logic              r_misalign;
    logic              w_misalign_req;
`endif

    logic              w_latch;
    logic              w_capture;
    logic              w_busy;
    logic [7:0]        w_strobe;
    logic [63:0]       w_wdata_al;
    logic [63:0]       w_load_data;

    mem_align u_align (
        .i_off      (r_addr[2:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (dbus.dresp.data),
        .o_strobe   (w_strobe),
        .o_wdata    (w_wdata_al),
        .o_rdata    (w_load_data)
    );

    assign w_busy = (r_state == WAIT_ADDR) || (r_state == WAIT_DATA);

`ifdef MAU_MISALIGN_TRAP_EN
    assign w_misalign_req = mau_misaligned(req_addr[2:0], msize_t'(req_size));
    assign misalign       = (r_state == DONE) && r_misalign;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_size      <= MSIZE1;
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_wdata     <= '0;
            r_flush     <= 1'b0;
            r_resp_data <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr     <= req_addr;
                r_size     <= msize_t'(req_size);
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
                r_flush    <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
                r_misalign <= w_misalign_req;
`endif
            end else if (w_busy) begin
                r_flush <= r_flush | flush;
            end
            if (w_capture) begin
                r_resp_data <= r_write ? '0 : w_load_data;
            end
        end
    end

    // data_ok alone completes the transfer, with or without a prior addr_ok.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && !flush) begin
                    w_latch = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
                    w_next  = w_misalign_req ? DONE : WAIT_ADDR;
`else
                    w_next  = WAIT_ADDR;
`endif
                end
            end
            WAIT_ADDR: begin
                if (dbus.dresp.data_ok) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end else if (dbus.dresp.addr_ok) begin
                    w_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (dbus.dresp.data_ok) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall     = req_valid && (r_state != DONE) && !((r_state == IDLE) && flush);
`ifdef MAU_MISALIGN_TRAP_EN
        resp_valid = (r_state == DONE) && !r_flush && !r_misalign;
`else
        resp_valid = (r_state == DONE) && !r_flush;
`endif
        resp_data = r_resp_data;
        dbus.dreq = '0;
        if (w_busy) begin
            dbus.dreq.valid  = 1'b1;
            dbus.dreq.addr   = r_addr;
            dbus.dreq.size   = r_size;
            dbus.dreq.strobe = r_write ? w_strobe : '0;
            dbus.dreq.data   = r_write ? w_wdata_al : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner sequences and random
// transactions against a byte-lane reference model (honours MAU_MISALIGN_TRAP_EN).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_data;
`ifdef MAU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_access_unit_if u_bus ();

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .flush        (flush),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
`ifdef MAU_MISALIGN_TRAP_EN
        .misalign     (misalign),
`endif
        .dbus         (u_bus)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic        na;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          aw;
        int          dw;
        int          fl;
        logic [7:0]  e_strb;
        logic [63:0] e_data;
        logic [63:0] e_resp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: build results lane by lane from the access size and offset.
    task automatic model(inout vec_t v);
        int off;
        int n;
        off      = int'(v.addr[2:0]);
        n        = 1 << v.sz;
        v.e_strb = '0;
        v.e_data = '0;
        v.e_resp = '0;
        for (int b = 0; b < 8; b++) begin
            if (b >= off) v.e_data[8*b +: 8] = v.wdata[8*(b-off) +: 8];
            if (v.wr && (n == 8 || (b >= off && b < off + n))) v.e_strb[b] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) v.e_resp[8*i +: 8] = v.rdata[8*(off+i) +: 8];
        end
        if (!v.uns && n < 8 && v.e_resp[8*n-1]) begin
            for (int i = n; i < 8; i++) v.e_resp[8*i +: 8] = 8'hFF;
        end
        if (v.wr) v.e_resp = '0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   k;
        logic done;
        logic flushed;
        req_valid    = 1'b1;
        req_write    = v.wr;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        flush        = 1'b0;
        #1;
        chk({tag, ".c0_stall"}, 64'(stall), 64'd1);
        chk({tag, ".c0_dvalid"}, 64'(u_bus.dreq.valid), 64'd0);
        step();
        k       = 0;
        done    = 1'b0;
        flushed = 1'b0;
        while (!done && k < 32) begin
            chk({tag, ".dvalid"}, 64'(u_bus.dreq.valid), 64'd1);
            chk({tag, ".daddr"}, u_bus.dreq.addr, v.addr);
            chk({tag, ".dsize"}, 64'(u_bus.dreq.size), 64'(v.sz));
            chk({tag, ".strobe"}, 64'(u_bus.dreq.strobe), 64'(v.e_strb));
            if (v.wr) chk({tag, ".ddata"}, u_bus.dreq.data, v.e_data);
            chk({tag, ".stall"}, 64'(stall), 64'd1);
            chk({tag, ".resp_early"}, 64'(resp_valid), 64'd0);
            flush = (k == v.fl);
            if (flush) flushed = 1'b1;
            u_bus.dresp.addr_ok = !v.na && (k == v.aw);
            u_bus.dresp.data_ok = (k == v.aw + v.dw);
            u_bus.dresp.data    = u_bus.dresp.data_ok ? v.rdata : {$urandom, $urandom};
            done = u_bus.dresp.data_ok;
            step();
            u_bus.dresp = '0;
            flush       = 1'b0;
            k++;
        end
        if (!done) chk({tag, ".timeout"}, 64'd0, 64'd1);
        chk({tag, ".done_stall"}, 64'(stall), 64'd0);
        chk({tag, ".done_dvalid"}, 64'(u_bus.dreq.valid), 64'd0);
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'(!flushed));
        if (!flushed) chk({tag, ".resp_data"}, resp_data, v.e_resp);
        step();
        req_valid = 1'b0;
        #1;
        chk({tag, ".idle_resp"}, 64'(resp_valid), 64'd0);
        chk({tag, ".idle_dvalid"}, 64'(u_bus.dreq.valid), 64'd0);
        chk({tag, ".idle_stall"}, 64'(stall), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        flush        = 1'b0;
        u_bus.dresp  = '0;

        // wr sz uns na addr wdata rdata aw dw fl strb data resp
        vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b0, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 64'h0,
                         0, 0, -1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 64'h0000_0000_8000_0003, 64'h0000_0000_0000_00AB, 64'h0,
                         0, 0, -1, 8'h08, 64'h0000_0000_AB00_0000, 64'h0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 1'b0, 64'h0000_0000_8000_0006, 64'h0, 64'h8001_0000_0000_0000,
                         0, 3, -1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 1'b0, 64'h0000_0000_8000_0006, 64'h0, 64'h8001_0000_0000_0000,
                         0, 3, -1, 8'h00, 64'h0, 64'h0000_0000_0000_8001});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 1'b0, 64'h0000_0000_1000_0005, 64'h0, 64'h0000_8000_0000_0000,
                         2, 0, -1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 1'b0, 64'h0000_0000_1000_1004, 64'h0, 64'h89AB_CDEF_0000_0000,
                         1, 1, -1, 8'h00, 64'h0, 64'hFFFF_FFFF_89AB_CDEF});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 1'b0, 64'h0000_0000_1000_1004, 64'h0, 64'h89AB_CDEF_0000_0000,
                         1, 1, -1, 8'h00, 64'h0, 64'h0000_0000_89AB_CDEF});
        vecs.push_back('{1'b0, 2'd3, 1'b1, 1'b0, 64'hFFFF_0000_0000_0008, 64'h0, 64'h8000_0000_0000_0001,
                         0, 0, -1, 8'h00, 64'h0, 64'h8000_0000_0000_0001});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b0, 64'h0000_0000_2000_0006, 64'h0000_0000_0000_1234, 64'h0,
                         1, 0, -1, 8'hC0, 64'h1234_0000_0000_0000, 64'h0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 1'b0, 64'h0000_0000_3000_0000, 64'h0, 64'h0123_4567_89AB_CDEF,
                         0, 2, 1, 8'h00, 64'h0, 64'h0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 64'h0000_0000_4000_0007, 64'h0000_0000_0000_005A, 64'h0,
                         1, 0, -1, 8'h80, 64'h5A00_0000_0000_0000, 64'h0});
`ifndef MAU_MISALIGN_TRAP_EN
        vecs.push_back('{1'b1, 2'd2, 1'b0, 1'b0, 64'h0000_0000_8000_0002, 64'h0000_0000_DEAD_BEEF, 64'h0,
                         0, 0, -1, 8'h3C, 64'h0000_DEAD_BEEF_0000, 64'h0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 1'b0, 64'h0000_0000_8000_0006, 64'h0000_0000_DEAD_BEEF, 64'h0,
                         0, 1, -1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0});
`endif

        repeat (3) step();
        chk("rst_dvalid", 64'(u_bus.dreq.valid), 64'd0);
        chk("rst_daddr", u_bus.dreq.addr, 64'd0);
        chk("rst_strobe", 64'(u_bus.dreq.strobe), 64'd0);
        chk("rst_ddata", u_bus.dreq.data, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        reset = 1'b1;
        step();
        chk("idle_stall", 64'(stall), 64'd0);
        chk("idle_dvalid", 64'(u_bus.dreq.valid), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush while a new request sits in IDLE: nothing issued, no stall.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd3;
        req_addr  = 64'h0000_0000_5000_0000;
        flush     = 1'b1;
        #1;
        chk("idleflush_stall", 64'(stall), 64'd0);
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk("idleflush_dvalid", 64'(u_bus.dreq.valid), 64'd0);
        chk("idleflush_resp", 64'(resp_valid), 64'd0);
        step();
        chk("idleflush_resp2", 64'(resp_valid), 64'd0);

        // Reset while in WAIT_ADDR, then a late data_ok must be ignored.
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_6000_0008;
        step();
        chk("rstmid_dvalid_pre", 64'(u_bus.dreq.valid), 64'd1);
        reset = 1'b0;
        step();
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rstmid_dvalid", 64'(u_bus.dreq.valid), 64'd0);
        chk("rstmid_stall", 64'(stall), 64'd0);
        u_bus.dresp.data_ok = 1'b1;
        u_bus.dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        u_bus.dresp = '0;
        chk("rstmid_resp", 64'(resp_valid), 64'd0);
        chk("rstmid_dvalid2", 64'(u_bus.dreq.valid), 64'd0);
        step();
        chk("rstmid_resp2", 64'(resp_valid), 64'd0);

`ifdef MAU_MISALIGN_TRAP_EN
        // Misaligned word load traps without touching the bus.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 64'h0000_0000_8000_0002;
        #1;
        chk("mis_c0_stall", 64'(stall), 64'd1);
        step();
        chk("mis_dvalid", 64'(u_bus.dreq.valid), 64'd0);
        chk("mis_flag", 64'(misalign), 64'd1);
        chk("mis_resp", 64'(resp_valid), 64'd0);
        chk("mis_stall", 64'(stall), 64'd0);
        step();
        req_valid = 1'b0;
        #1;
        chk("mis_flag_clr", 64'(misalign), 64'd0);
        chk("mis_dvalid2", 64'(u_bus.dreq.valid), 64'd0);
`endif

        for (int t = 0; t < 200; t++) begin
            vec_t v;
            v.wr    = 1'($urandom_range(0, 1));
            v.sz    = 2'($urandom_range(0, 3));
            v.uns   = 1'($urandom_range(0, 1));
            v.addr  = {$urandom, $urandom};
`ifdef MAU_MISALIGN_TRAP_EN
            v.addr[2:0] = v.addr[2:0] & ~(3'((4'd1 << v.sz) - 4'd1));
`endif
            v.wdata = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.aw    = int'($urandom_range(0, 2));
            v.dw    = int'($urandom_range(0, 3));
            v.na    = ($urandom_range(0, 7) == 0);
            v.fl    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(v.aw + v.dw))) : -1;
            model(v);
            run_txn(v, $sformatf("rnd%0d", t));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine between the pipeline's execute/memory register and the data bus (dbus_req_t / dbus_resp_t).
- Turns one memory-stage request into exactly one dbus transaction and holds the pipeline stalled until the transaction completes.
- Generates byte strobes and lane-aligned store data; extracts and extends load data.

Parameters:
- ADDR_W, 64, address width; matches u64 pc/addr.
- DATA_W, 64, bus data width; fixed 8 byte lanes.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low; state is cleared on a clk edge when reset==0.
- req_valid  input  1  memory-stage instruction is a load or store.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  0=byte, 1=half, 2=word, 3=dword.
- req_unsigned  input  1  zero-extend load (LBU/LHU/LWU).
- req_addr  input  64  effective address (ALU result).
- req_wdata  input  64  store source, right-aligned.
- flush  input  1  squash the current request's result.
- stall  output  1  hold all upstream pipeline registers.
- resp_valid  output  1  one-cycle pulse; load data or store completion.
- resp_data  output  64  extended load result; 0 for stores.
- dreq  output  dbus_req_t  valid/addr/size/strobe/data.
- dresp  input  dbus_resp_t  addr_ok/data_ok/data.

Behaviour:
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, DONE. Reset state is IDLE.
- Reset values: dreq all 0, stall 0, resp_valid 0, resp_data 0.
- IDLE:
  - When req_valid=1, latch addr, size, write, unsigned and wdata; go to WAIT_ADDR.
  - stall is combinational: req_valid & (state!=DONE). It is high in the cycle the request first appears.
- WAIT_ADDR:
  - dreq.valid=1, driven from registered fields only.
  - Fields stay stable until addr_ok.
  - addr_ok&data_ok → DONE. addr_ok only → WAIT_DATA.
- WAIT_DATA:
  - dreq.valid=1; fields unchanged.
  - data_ok → DONE. Capture the extracted load data into resp_data.
- DONE:
  - stall=0. resp_valid=1 unless the request was flushed.
  - The next edge advances the pipeline; go to IDLE.
  - The request seen in IDLE after DONE is a new instruction.
- Minimum latency: request at cycle 0, dreq.valid at cycle 1, DONE/resp_valid at cycle 2 when addr_ok and data_ok arrive together in cycle 1.
- Store strobe and data:
  - Byte: strobe = 8'h01<<addr[2:0].
  - Half: 8'h03<<addr[2:0].
  - Word: 8'h0F<<addr[2:0].
  - Dword: 8'hFF.
  - dreq.data = wdata<<(8*addr[2:0]).
- Loads:
  - strobe=0.
  - Raw value = dresp.data>>(8*addr[2:0]), truncated to size.
  - Sign-extend unless req_unsigned. Dword ignores req_unsigned.
- dreq.addr is the full req_addr, unmodified. dreq.size = req_size.
- Flush:
  - Flush in IDLE with req_valid: no transaction is issued, stall=0, no response.
  - Flush in WAIT_ADDR or WAIT_DATA: the bus handshake still completes (valid is never dropped early). Record the flush; in DONE resp_valid=0.
- Reset mid-transaction: dreq.valid drops on the reset edge; the FSM returns to IDLE and any late data_ok is ignored.
- Simultaneous events:
  - addr_ok and data_ok in the same cycle: treat as complete.
  - data_ok without prior addr_ok: treat as complete.
  - req_valid=0 in IDLE: outputs idle, no stall.

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN.
- Defined:
  - A request with addr not aligned to 2^size is not issued; the FSM goes straight to DONE.
  - An extra output misalign (1-bit) pulses with the DONE cycle; resp_valid=0.
- Undefined:
  - No check and no misalign port. The bus receives the raw address and strobes may shift past bit 7; the upper strobes are truncated.

Decomposition:
- Package common: msize_t enum (MSIZE1/2/4/8) and mau_state_t enum.
- Sub-module mem_align (combinational): strobe/wdata generation and load extract/extend. The FSM stays in mem_access_unit.

Test Plan:
- SD, addr 0x8000_0010, wdata 0x1122334455667788, addr_ok+data_ok on cycle 1 → strobe 0xFF, data unchanged, stall high cycles 0–1, resp_valid cycle 2.
- SB, addr 0x8000_0003, wdata 0xAB → strobe 0x08, dreq.data 0x00000000AB000000 (lane 3).
- LH signed, addr 0x...6, dresp.data 0x8001_0000_0000_0000 with data_ok 3 cycles after addr_ok → resp_data 0xFFFF_FFFF_FFFF_8001, dreq fields stable throughout. LHU on the same data → 0x8001.
- Flush asserted while in WAIT_DATA → dreq.valid held until data_ok; resp_valid stays 0; stall releases in DONE.
- reset=0 while in WAIT_ADDR → next cycle dreq.valid=0, state IDLE; subsequent data_ok produces no resp_valid.
- With MAU_MISALIGN_TRAP_EN: LW at 0x...2 → no dreq.valid, misalign=1 one cycle after request. Without it: the same request issues with strobe 0x3C.
